icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller.
- Serves imemaddr/imemREN requests, returning ihit/imemload to the datapath.
- On a miss, runs a single-word fill from memory over an iREN/iwait handshake.
- The datapath stalls its PC and IF/ID latch on !ihit, so this block's hit timing directly sets fetch throughput.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/icache_frame_array.sv | 39 +++
 rtl/icache_dm.sv | 81 ++++++++
 tb/tb_icache_dm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, instruction-cache frame/address and FSM types.
package cpu_types_pkg;
  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;
  typedef enum logic {IDLE, FILL} icache_state_t;
endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: SETS frames, one combinational read port, one synchronous write port.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IW    = $clog2(SETS),
  parameter int TAG_W = ITAG_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IW-1:0]    ridx_i,
  output logic             rvalid_o,
  output logic [TAG_W-1:0] rtag_o,
  output word_t            rdata_o,
  input  logic             we_i,
  input  logic [IW-1:0]    widx_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  word_t            wdata_i
);
  logic             valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS];
  word_t            data_q  [SETS];
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
      tag_q[widx_i]   <= wtag_i;
      data_q[widx_i]  <= wdata_i;
    end
  end
  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-word fill.
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [31:0]       imemload,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [31:0]       iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW - 2;
  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              rvalid, miss_start, fill_done;
  logic [TW-1:0]     rtag;
  word_t             rdata;
  icache_frame_array #(.SETS(SETS), .IW(IW), .TAG_W(TW)) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .ridx_i   (imemaddr[IW+1:2]),
    .rvalid_o (rvalid),
    .rtag_o   (rtag),
    .rdata_o  (rdata),
    .we_i     (fill_done),
    .widx_i   (miss_addr_q[IW+1:2]),
    .wtag_i   (miss_addr_q[ADDR_W-1:IW+2]),
    .wdata_i  (iload)
  );
  always_comb begin
    ihit        = imemREN && rvalid && rtag == imemaddr[ADDR_W-1:IW+2] && state_q == IDLE;
    imemload    = ihit ? rdata : '0;
    iREN        = state_q == FILL;
    iaddr       = iREN ? miss_addr_q : '0;
    miss_start  = state_q == IDLE && imemREN && !ihit;
    fill_done   = state_q == FILL && !iwait;
    miss_addr_d = miss_start ? imemaddr & ~ADDR_W'(3) : miss_addr_q;
    state_d     = miss_start ? FILL : fill_done ? IDLE : state_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  always_comb begin
    hit_count_d  = ihit && hit_count_q != '1 ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = miss_start && miss_count_q != '1 ? miss_count_q + 32'd1 : miss_count_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed scenario tests for icache_dm; inputs change and outputs are sampled around the falling edge.
module tb_icache_dm;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  icache_dm dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    imemREN = 1'b1;
    imemaddr = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    total_cnt++; if (ihit !== 1'b0) $display("FAIL reset_ihit got %0b want 0", ihit); else pass_cnt++;
    total_cnt++; if (imemload !== 32'h0) $display("FAIL reset_imemload got %h want 0", imemload); else pass_cnt++;
    total_cnt++; if (iREN !== 1'b0) $display("FAIL reset_iREN got %0b want 0", iREN); else pass_cnt++;
    total_cnt++; if (iaddr !== 32'h0) $display("FAIL reset_iaddr got %h want 0", iaddr); else pass_cnt++;
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_fetch();
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h3C010001;
    #1;
    total_cnt++; if (ihit !== 1'b0) $display("FAIL cold_c0_ihit got %0b want 0", ihit); else pass_cnt++;
    total_cnt++; if (iREN !== 1'b0) $display("FAIL cold_c0_iREN got %0b want 0", iREN); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      if (i == 3) iwait = 1'b0;
      #1;
      total_cnt++; if (ihit !== 1'b0) $display("FAIL cold_c%0d_ihit got %0b want 0", i, ihit); else pass_cnt++;
      total_cnt++; if (iREN !== 1'b1 || iaddr !== 32'h0) $display("FAIL cold_c%0d_fill got iREN=%0b iaddr=%h want 1/0", i, iREN, iaddr); else pass_cnt++;
    end
    @(negedge CLK);
    #1;
    total_cnt++; if (ihit !== 1'b1 || imemload !== 32'h3C010001) $display("FAIL cold_hit got ihit=%0b load=%h want 1/3c010001", ihit, imemload); else pass_cnt++;
    total_cnt++; if (iREN !== 1'b0) $display("FAIL cold_hit_iREN got %0b want 0", iREN); else pass_cnt++;
  endtask

  task automatic test_warm_hit();
    imemaddr = 32'h3;
    #1;
    total_cnt++; if (ihit !== 1'b1 || imemload !== 32'h3C010001) $display("FAIL warm_off3 got ihit=%0b load=%h want 1/3c010001", ihit, imemload); else pass_cnt++;
    @(negedge CLK);
    imemaddr = 32'h0;
    #1;
    total_cnt++; if (ihit !== 1'b1 || iREN !== 1'b0) $display("FAIL warm_again got ihit=%0b iREN=%0b want 1/0", ihit, iREN); else pass_cnt++;
    imemREN = 1'b0;
    #1;
    total_cnt++; if (ihit !== 1'b0 || imemload !== 32'h0) $display("FAIL warm_noren got ihit=%0b load=%h want 0/0", ihit, imemload); else pass_cnt++;
  endtask

  task automatic test_conflict();
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'hAAAA0040;
    #1;
    total_cnt++; if (ihit !== 1'b0) $display("FAIL conf_miss got %0b want 0", ihit); else pass_cnt++;
    @(negedge CLK);
    #1;
    total_cnt++; if (iREN !== 1'b1 || iaddr !== 32'h40) $display("FAIL conf_fill got iREN=%0b iaddr=%h want 1/40", iREN, iaddr); else pass_cnt++;
    @(negedge CLK);
    #1;
    total_cnt++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0040) $display("FAIL conf_hit got ihit=%0b load=%h want 1/aaaa0040", ihit, imemload); else pass_cnt++;
    imemaddr = 32'h0;
    #1;
    total_cnt++; if (ihit !== 1'b0 || imemload !== 32'h0) $display("FAIL conf_evicted got ihit=%0b load=%h want 0/0", ihit, imemload); else pass_cnt++;
    imemREN = 1'b0;
  endtask

  task automatic test_addr_change();
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1; iload = 32'h11110010;
    @(negedge CLK);
    imemaddr = 32'h20;
    #1;
    total_cnt++; if (iREN !== 1'b1 || iaddr !== 32'h10 || ihit !== 1'b0) $display("FAIL chg_fill got iREN=%0b iaddr=%h ihit=%0b want 1/10/0", iREN, iaddr, ihit); else pass_cnt++;
    @(negedge CLK);
    iwait = 1'b0;
    #1;
    total_cnt++; if (iaddr !== 32'h10) $display("FAIL chg_latched got iaddr=%h want 10", iaddr); else pass_cnt++;
    @(negedge CLK);
    iload = 32'h22220020;
    #1;
    total_cnt++; if (ihit !== 1'b0 || iREN !== 1'b0) $display("FAIL chg_new_miss got ihit=%0b iREN=%0b want 0/0", ihit, iREN); else pass_cnt++;
    @(negedge CLK);
    #1;
    total_cnt++; if (iREN !== 1'b1 || iaddr !== 32'h20) $display("FAIL chg_fill2 got iREN=%0b iaddr=%h want 1/20", iREN, iaddr); else pass_cnt++;
    @(negedge CLK);
    #1;
    total_cnt++; if (ihit !== 1'b1 || imemload !== 32'h22220020) $display("FAIL chg_hit20 got ihit=%0b load=%h want 1/22220020", ihit, imemload); else pass_cnt++;
    imemaddr = 32'h10;
    #1;
    total_cnt++; if (ihit !== 1'b1 || imemload !== 32'h11110010) $display("FAIL chg_hit10 got ihit=%0b load=%h want 1/11110010", ihit, imemload); else pass_cnt++;
    imemREN = 1'b0;
  endtask

  task automatic test_reset_midfill();
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1; iload = 32'h88880080;
    @(negedge CLK);
    #1;
    total_cnt++; if (iREN !== 1'b1 || iaddr !== 32'h80) $display("FAIL rst_fill got iREN=%0b iaddr=%h want 1/80", iREN, iaddr); else pass_cnt++;
    nRST = 1'b0; iwait = 1'b0;
    #1;
    total_cnt++; if (iREN !== 1'b0 || iaddr !== 32'h0) $display("FAIL rst_async got iREN=%0b iaddr=%h want 0/0", iREN, iaddr); else pass_cnt++;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    imemaddr = 32'h10;
    #1;
    total_cnt++; if (ihit !== 1'b0) $display("FAIL rst_cleared got ihit=%0b want 0", ihit); else pass_cnt++;
    imemaddr = 32'h80;
    #1;
    total_cnt++; if (ihit !== 1'b0 || iREN !== 1'b0) $display("FAIL rst_nowrite got ihit=%0b iREN=%0b want 0/0", ihit, iREN); else pass_cnt++;
    imemREN = 1'b0;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    total_cnt++; if (hit_count !== 32'd0 || miss_count !== 32'd0) $display("FAIL stats_reset got hit=%0d miss=%0d want 0/0", hit_count, miss_count); else pass_cnt++;
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b0; iload = 32'h01000100;
    repeat (2) @(negedge CLK);
    repeat (6) @(negedge CLK);
    imemREN = 1'b0;
    #1;
    total_cnt++; if (miss_count !== 32'd1) $display("FAIL stats_miss got %0d want 1", miss_count); else pass_cnt++;
    total_cnt++; if (hit_count !== 32'd6) $display("FAIL stats_hit got %0d want 6", hit_count); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_fetch();
    test_warm_hit();
    test_conflict();
    test_addr_change();
    test_reset_midfill();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
